// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the RV32I multicycle control: opcodes, FSM states,
// datapath mux selects and ULA operation classes.
package pkg_controle;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_WB_ULA = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_WB_MEM = 4'd7,
    ST_MEM_WR = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JAL    = 4'd10,
    ST_JALR   = 4'd11,
    ST_LUI    = 4'd12,
    ST_ERRO   = 4'd15
  } estado_t;

  localparam logic [1:0] M2R_ULAOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_IMM    = 2'b11;

  localparam logic [1:0] PC_ULA     = 2'b00;
  localparam logic [1:0] PC_ULAOUT  = 2'b01;
  localparam logic [1:0] PC_JALR    = 2'b10;

  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_RS1      = 2'b01;
  localparam logic [1:0] A_PCANTIGO = 2'b10;

  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_4        = 2'b01;
  localparam logic [1:0] B_IMM      = 2'b10;

  localparam logic [1:0] ULA_ADD    = 2'b00;
  localparam logic [1:0] ULA_SUB    = 2'b01;
  localparam logic [1:0] ULA_FUNCT  = 2'b10;

  function automatic estado_t decode_opcode(input logic [6:0] opc);
    case (opc)
      OPC_R:               return ST_EXEC_R;
      OPC_I:               return ST_EXEC_I;
      OPC_LOAD, OPC_STORE: return ST_ADDR;
      OPC_BRANCH:          return ST_BRANCH;
      OPC_JAL:             return ST_JAL;
      OPC_JALR:            return ST_JALR;
      OPC_LUI:             return ST_LUI;
      default:             return ST_ERRO;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_contador.sv
// Wrapping performance counter: advances by one on each edge where both
// inc_i and en_i are high.
module contador_desempenho #(
  parameter int W_CONT = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              inc_i,
  input  logic              en_i,
  output logic [W_CONT-1:0] count_o
);

  logic [W_CONT-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      count_q <= '0;
    else if (inc_i && en_i)
      count_q <= count_q + W_CONT'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV32I datapath with a ready-handshake
// shared memory, plus retired-instruction and cycle counters.
module controle_multiciclo
  import pkg_controle::*;
#(
  parameter int W_CONT = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [6:0]        iOpcode,
  input  logic [2:0]        iFunct3,
  input  logic              iCond,
  input  logic              iMemPronto,
  output logic              oEscIR,
  output logic              oEscPC,
  output logic              oEscPCAntigo,
  output logic              oIouD,
  output logic              oLeMem,
  output logic              oEscMem,
  output logic              oEscReg,
  output logic [1:0]        oMem2Reg,
  output logic [1:0]        oOrigPC,
  output logic [1:0]        oOrigAULA,
  output logic [1:0]        oOrigBULA,
  output logic [1:0]        oULAOp,
  output logic [3:0]        oEstado,
  output logic              oErro,
  output logic [W_CONT-1:0] oNumInst,
  output logic [W_CONT-1:0] oNumCiclos
);

  estado_t state_q, state_d;
  logic    erro_q;
  logic    retire;

  // The branch comparator already resolves funct3, so the FSM never needs it.
  logic unused_funct3;
  assign unused_funct3 = ^iFunct3;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    oEscIR       = 1'b0;
    oEscPC       = 1'b0;
    oEscPCAntigo = 1'b0;
    oIouD        = 1'b0;
    oLeMem       = 1'b0;
    oEscMem      = 1'b0;
    oEscReg      = 1'b0;
    oMem2Reg     = M2R_ULAOUT;
    oOrigPC      = PC_ULA;
    oOrigAULA    = A_PC;
    oOrigBULA    = B_RS2;
    oULAOp       = ULA_ADD;

    case (state_q)
      ST_FETCH: begin
        oLeMem    = 1'b1;
        oOrigBULA = B_4;
        if (iMemPronto) begin
          oEscIR       = 1'b1;
          oEscPC       = 1'b1;
          oEscPCAntigo = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        oOrigAULA = A_PCANTIGO;
        oOrigBULA = B_IMM;
        state_d   = decode_opcode(iOpcode);
      end
      ST_EXEC_R: begin
        oOrigAULA = A_RS1;
        oULAOp    = ULA_FUNCT;
        state_d   = ST_WB_ULA;
      end
      ST_EXEC_I: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        oULAOp    = ULA_FUNCT;
        state_d   = ST_WB_ULA;
      end
      ST_WB_ULA: begin
        oEscReg = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ADDR: begin
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        state_d   = (iOpcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        oLeMem = 1'b1;
        oIouD  = 1'b1;
        if (iMemPronto) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        oEscReg  = 1'b1;
        oMem2Reg = M2R_MDR;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_WR: begin
        oEscMem = 1'b1;
        oIouD   = 1'b1;
        if (iMemPronto) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        oOrigAULA = A_RS1;
        oULAOp    = ULA_SUB;
        if (iCond) begin
          oEscPC  = 1'b1;
          oOrigPC = PC_ULAOUT;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        oEscReg  = 1'b1;
        oMem2Reg = M2R_PC;
        oEscPC   = 1'b1;
        oOrigPC  = PC_ULAOUT;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JALR: begin
        // rd takes the old PC because PC and register bank write on one edge.
        oOrigAULA = A_RS1;
        oOrigBULA = B_IMM;
        oEscPC    = 1'b1;
        oOrigPC   = PC_JALR;
        oEscReg   = 1'b1;
        oMem2Reg  = M2R_PC;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_LUI: begin
        oEscReg  = 1'b1;
        oMem2Reg = M2R_IMM;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ERRO: state_d = ST_ERRO;
      default: state_d = ST_ERRO;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_FETCH;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_ERRO) erro_q <= 1'b1;
    end
  end

  assign oEstado = state_q;
  assign oErro   = erro_q;

  contador_desempenho #(.W_CONT(W_CONT)) u_cont_inst (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .inc_i   (retire),
    .en_i    (1'b1),
    .count_o (oNumInst)
  );

  contador_desempenho #(.W_CONT(W_CONT)) u_cont_ciclos (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .inc_i   (1'b1),
    .en_i    (state_q != ST_ERRO),
    .count_o (oNumCiclos)
  );

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: a 32-bit instance walks the
// instruction classes, a 4-bit instance exercises counter wrap.
module tb_controle_multiciclo;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic        iRST, iCond, iMemPronto;
  logic [6:0]  iOpcode;
  logic [2:0]  iFunct3;
  logic        oEscIR, oEscPC, oEscPCAntigo, oIouD, oLeMem, oEscMem, oEscReg, oErro;
  logic [1:0]  oMem2Reg, oOrigPC, oOrigAULA, oOrigBULA, oULAOp;
  logic [3:0]  oEstado;
  logic [31:0] oNumInst, oNumCiclos;

  logic        rst_s, cond_s, pronto_s;
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic        s_escIR, s_escPC, s_escPCAntigo, s_iouD, s_leMem, s_escMem, s_escReg, s_erro;
  logic [1:0]  s_mem2reg, s_origPC, s_origA, s_origB, s_ulaop;
  logic [3:0]  s_estado;
  logic [3:0]  s_inst, s_ciclos;

  int n_checks = 0;
  int n_fail   = 0;

  controle_multiciclo #(.W_CONT(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iOpcode(iOpcode), .iFunct3(iFunct3),
    .iCond(iCond), .iMemPronto(iMemPronto),
    .oEscIR(oEscIR), .oEscPC(oEscPC), .oEscPCAntigo(oEscPCAntigo),
    .oIouD(oIouD), .oLeMem(oLeMem), .oEscMem(oEscMem), .oEscReg(oEscReg),
    .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC), .oOrigAULA(oOrigAULA),
    .oOrigBULA(oOrigBULA), .oULAOp(oULAOp), .oEstado(oEstado), .oErro(oErro),
    .oNumInst(oNumInst), .oNumCiclos(oNumCiclos)
  );

  controle_multiciclo #(.W_CONT(4)) dut_s (
    .iCLK(iCLK), .iRST(rst_s), .iOpcode(opc_s), .iFunct3(f3_s),
    .iCond(cond_s), .iMemPronto(pronto_s),
    .oEscIR(s_escIR), .oEscPC(s_escPC), .oEscPCAntigo(s_escPCAntigo),
    .oIouD(s_iouD), .oLeMem(s_leMem), .oEscMem(s_escMem), .oEscReg(s_escReg),
    .oMem2Reg(s_mem2reg), .oOrigPC(s_origPC), .oOrigAULA(s_origA),
    .oOrigBULA(s_origB), .oULAOp(s_ulaop), .oEstado(s_estado), .oErro(s_erro),
    .oNumInst(s_inst), .oNumCiclos(s_ciclos)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST = 1'b1; iMemPronto = 1'b0; iOpcode = 7'h33; iFunct3 = 3'd0; iCond = 1'b0;
    rst_s = 1'b1; pronto_s = 1'b1; opc_s = 7'h37; f3_s = 3'd0; cond_s = 1'b0;
    step(); step();

    check("rst_estado", oEstado, 0);
    check("rst_inst", oNumInst, 0);
    check("rst_ciclos", oNumCiclos, 0);
    check("rst_erro", oErro, 0);
    check("fetch_wait_lemem", oLeMem, 1);
    check("fetch_wait_iouD", oIouD, 0);
    check("fetch_wait_escIR", oEscIR, 0);
    check("fetch_wait_escPC", oEscPC, 0);
    check("fetch_origB", oOrigBULA, 2'b01);
    check("fetch_origA", oOrigAULA, 2'b00);
    iMemPronto = 1'b1;
    #1;
    check("fetch_rdy_escIR", oEscIR, 1);
    check("fetch_rdy_escPC", oEscPC, 1);
    check("fetch_rdy_escPCAntigo", oEscPCAntigo, 1);
    check("fetch_rdy_origPC", oOrigPC, 2'b00);
    iRST = 1'b0;

    // add x3,x1,x2
    step(); check("add_s1", oEstado, 1); check("add_dec_escReg", oEscReg, 0);
    check("dec_origA", oOrigAULA, 2'b10); check("dec_origB", oOrigBULA, 2'b10);
    step(); check("add_s2", oEstado, 2); check("add_exec_escReg", oEscReg, 0);
    check("execR_origA", oOrigAULA, 2'b01); check("execR_origB", oOrigBULA, 2'b00);
    check("execR_ulaop", oULAOp, 2'b10);
    step(); check("add_s4", oEstado, 4); check("add_wb_escReg", oEscReg, 1);
    check("add_wb_mem2reg", oMem2Reg, 2'b00);
    step(); check("add_s0", oEstado, 0); check("add_inst", oNumInst, 1);
    check("add_ciclos", oNumCiclos, 4); check("add_fetch_escReg", oEscReg, 0);

    // lw with three wait cycles in MEM_RD
    iOpcode = 7'h03;
    step(); check("lw_s1", oEstado, 1);
    step(); check("lw_s5", oEstado, 5); check("lw_addr_origB", oOrigBULA, 2'b10);
    step(); iMemPronto = 1'b0;
    check("lw_s6_0", oEstado, 6); check("lw_lemem_0", oLeMem, 1); check("lw_iouD_0", oIouD, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("lw_s6_%0d", i), oEstado, 6);
      check($sformatf("lw_lemem_%0d", i), oLeMem, 1);
      check($sformatf("lw_iouD_%0d", i), oIouD, 1);
    end
    iMemPronto = 1'b1;
    step(); check("lw_s7", oEstado, 7); check("lw_mem2reg", oMem2Reg, 2'b01);
    check("lw_escReg", oEscReg, 1);
    step(); check("lw_s0", oEstado, 0); check("lw_inst", oNumInst, 2);
    check("lw_ciclos", oNumCiclos, 12);

    // beq taken
    iOpcode = 7'h63; iCond = 1'b1;
    step(); step();
    check("beq1_s9", oEstado, 9); check("beq1_escPC", oEscPC, 1);
    check("beq1_origPC", oOrigPC, 2'b01); check("beq1_ulaop", oULAOp, 2'b01);
    step(); check("beq1_s0", oEstado, 0); check("beq1_inst", oNumInst, 3);
    check("beq1_ciclos", oNumCiclos, 15);

    // beq not taken
    iCond = 1'b0;
    step(); step();
    check("beq0_s9", oEstado, 9); check("beq0_escPC", oEscPC, 0);
    step(); check("beq0_inst", oNumInst, 4); check("beq0_ciclos", oNumCiclos, 18);

    // jal
    iOpcode = 7'h6F;
    step(); step();
    check("jal_s10", oEstado, 10); check("jal_escReg", oEscReg, 1);
    check("jal_mem2reg", oMem2Reg, 2'b10); check("jal_origPC", oOrigPC, 2'b01);
    check("jal_escPC", oEscPC, 1);
    step(); check("jal_s0", oEstado, 0); check("jal_ciclos", oNumCiclos, 21);

    // jalr
    iOpcode = 7'h67;
    step(); step();
    check("jalr_s11", oEstado, 11); check("jalr_origPC", oOrigPC, 2'b10);
    check("jalr_origB", oOrigBULA, 2'b10); check("jalr_escReg", oEscReg, 1);
    check("jalr_mem2reg", oMem2Reg, 2'b10);
    step(); check("jalr_inst", oNumInst, 6); check("jalr_ciclos", oNumCiclos, 24);

    // sw
    iOpcode = 7'h23;
    step(); step(); step();
    check("sw_s8", oEstado, 8); check("sw_escMem", oEscMem, 1);
    check("sw_iouD", oIouD, 1); check("sw_lemem", oLeMem, 0);
    step(); check("sw_s0", oEstado, 0); check("sw_inst", oNumInst, 7);
    check("sw_ciclos", oNumCiclos, 28);

    // illegal opcode
    iOpcode = 7'h7F;
    step(); step();
    check("err_s15", oEstado, 15); check("err_flag", oErro, 1);
    check("err_inst", oNumInst, 7); check("err_ciclos", oNumCiclos, 30);
    check("err_escPC", oEscPC, 0); check("err_lemem", oLeMem, 0);
    for (int i = 0; i < 3; i++) begin
      iMemPronto = i[0];
      step();
    end
    iMemPronto = 1'b1;
    check("err_hold_s15", oEstado, 15); check("err_hold_ciclos", oNumCiclos, 30);
    check("err_hold_inst", oNumInst, 7); check("err_hold_flag", oErro, 1);
    #2 iRST = 1'b1;
    #1;
    check("err_rst_s0", oEstado, 0); check("err_rst_flag", oErro, 0);
    check("err_rst_inst", oNumInst, 0); check("err_rst_ciclos", oNumCiclos, 0);
    #2 iRST = 1'b0;

    // reset during a FETCH wait
    iMemPronto = 1'b0;
    step(); step();
    check("fw_s0", oEstado, 0); check("fw_ciclos", oNumCiclos, 2);
    check("fw_escIR", oEscIR, 0);
    #2 iRST = 1'b1;
    #1;
    check("fw_rst_s0", oEstado, 0); check("fw_rst_ciclos", oNumCiclos, 0);
    check("fw_rst_lemem", oLeMem, 1); check("fw_rst_escMem", oEscMem, 0);
    #2 iRST = 1'b0;

    // reset during a MEM_RD wait drops the data request
    iMemPronto = 1'b1; iOpcode = 7'h03;
    step(); step(); step();
    iMemPronto = 1'b0;
    step();
    check("mw_s6", oEstado, 6); check("mw_iouD", oIouD, 1);
    #2 iRST = 1'b1;
    #1;
    check("mw_rst_s0", oEstado, 0); check("mw_rst_iouD", oIouD, 0);
    check("mw_rst_lemem", oLeMem, 1); check("mw_rst_ciclos", oNumCiclos, 0);

    // 4-bit counters: 16 LUIs wrap the retired count to zero
    rst_s = 1'b0;
    step(); step();
    check("lui_s12", s_estado, 12); check("lui_mem2reg", s_mem2reg, 2'b11);
    check("lui_escReg", s_escReg, 1);
    step(); check("lui_inst1", s_inst, 1);
    for (int i = 0; i < 42; i++) step();
    check("wrap_inst15", s_inst, 15); check("wrap_ciclos45", s_ciclos, 13);
    step(); step(); step();
    check("wrap_inst0", s_inst, 0); check("wrap_ciclos48", s_ciclos, 0);
    check("wrap_s0", s_estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
